prga_decrypt_fsm: RTL and testbench

- RC4 pseudo-random generation and decrypt stage. It sits directly downstream of the key-scheduling shuffle FSM.
- Once the shuffle reports completion, it takes ownership of the 256x8 S RAM. It generates one keystream byte per message byte.
- Each keystream byte is XORed with the encrypted-message ROM byte, and the result is written to the decrypted-message RAM.
- It flags whether every decrypted byte is printable lowercase or space. The key-search controller uses this flag to accept or reject the current key.

---
 rtl/prga_decrypt_fsm.sv | 154 +++++++++++++++
 tb/tb_prga_decrypt_fsm.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prga_decrypt_fsm.sv
// RC4 keystream generator and message decrypt stage: owns the S RAM after the key-schedule
// shuffle, XORs each keystream byte with the encrypted ROM and writes the result to the decrypted RAM.
module prga_decrypt_fsm #(
   parameter int unsigned MSG_LEN     = 32,
   parameter int unsigned MSG_AW      = 5,
   parameter bit          EARLY_ABORT = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        s_q,
   output logic [7:0]        s_address,
   output logic [7:0]        s_data,
   output logic              s_wren,
   input  logic [7:0]        enc_q,
   output logic [MSG_AW-1:0] enc_address,
   output logic [MSG_AW-1:0] dec_address,
   output logic [7:0]        dec_data,
   output logic              dec_wren,
   output logic              busy,
   output logic              done,
   output logic              msg_valid
);

   localparam logic [7:0] LAST_K = 8'(MSG_LEN - 1);

   typedef enum logic [4:0] {
      IDLE, INC_I, RD_SI, WAIT_SI, LATCH_SI, CALC_J, RD_SJ, WAIT_SJ, LATCH_SJ,
      WR_SI, WR_SJ, RD_F, WAIT_F, LATCH_F, WR_DEC, CHECK, DONE
   } state_t;

   state_t     state;
   logic [7:0] i, j, k, si, sj, f, enc_byte;
   logic       byte_ok_c;

   // Accept only lowercase letters and space in the decrypted text.
   always_comb begin
      byte_ok_c = ((dec_data >= 8'h61) && (dec_data <= 8'h7a)) || (dec_data == 8'h20);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         i           <= 8'd0;
         j           <= 8'd0;
         k           <= 8'd0;
         si          <= 8'd0;
         sj          <= 8'd0;
         f           <= 8'd0;
         enc_byte    <= 8'd0;
         s_address   <= 8'd0;
         s_data      <= 8'd0;
         s_wren      <= 1'b0;
         enc_address <= '0;
         dec_address <= '0;
         dec_data    <= 8'd0;
         dec_wren    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         msg_valid   <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  i         <= 8'd0;
                  j         <= 8'd0;
                  k         <= 8'd0;
                  msg_valid <= 1'b1;
                  busy      <= 1'b1;
                  state     <= INC_I;
               end
            end
            INC_I: begin
               i     <= i + 8'd1;
               state <= RD_SI;
            end
            RD_SI: begin
               s_address <= i;
               state     <= WAIT_SI;
            end
            WAIT_SI:  state <= LATCH_SI;
            LATCH_SI: begin
               si    <= s_q;
               state <= CALC_J;
            end
            CALC_J: begin
               j     <= j + si;
               state <= RD_SJ;
            end
            RD_SJ: begin
               s_address <= j;
               state     <= WAIT_SJ;
            end
            WAIT_SJ:  state <= LATCH_SJ;
            LATCH_SJ: begin
               sj    <= s_q;
               state <= WR_SI;
            end
            // Swap S[i] and S[j]; i==j simply writes the same value twice.
            WR_SI: begin
               s_address <= i;
               s_data    <= sj;
               s_wren    <= 1'b1;
               state     <= WR_SJ;
            end
            WR_SJ: begin
               s_address <= j;
               s_data    <= si;
               s_wren    <= 1'b1;
               state     <= RD_F;
            end
            RD_F: begin
               s_wren      <= 1'b0;
               s_address   <= si + sj;
               enc_address <= MSG_AW'(k);
               state       <= WAIT_F;
            end
            WAIT_F:  state <= LATCH_F;
            LATCH_F: begin
               f        <= s_q;
               enc_byte <= enc_q;
               state    <= WR_DEC;
            end
            WR_DEC: begin
               dec_address <= MSG_AW'(k);
               dec_data    <= f ^ enc_byte;
               dec_wren    <= 1'b1;
               state       <= CHECK;
            end
            CHECK: begin
               dec_wren <= 1'b0;
               if (!byte_ok_c) msg_valid <= 1'b0;
               if ((EARLY_ABORT && !byte_ok_c) || (k == LAST_K)) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  k     <= k + 8'd1;
                  state <= INC_I;
               end
            end
            // Holding start keeps us here so one start assertion yields exactly one run.
            DONE: begin
               if (!start) begin
                  done  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prga_decrypt_fsm.sv
// Directed bench for prga_decrypt_fsm: two instances (early abort on/off) with behavioural
// S RAM, encrypted ROM and decrypted RAM models using a two-edge read latency.
module tb_prga_decrypt_fsm;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, start0, start1, mem_init, sel;
   logic [7:0] s_q0, s_address0, s_data0, enc_q0, dec_data0;
   logic [7:0] s_q1, s_address1, s_data1, enc_q1, dec_data1;
   logic [4:0] enc_address0, dec_address0, enc_address1, dec_address1;
   logic       s_wren0, dec_wren0, busy0, done0, msg_valid0;
   logic       s_wren1, dec_wren1, busy1, done1, msg_valid1;

   logic [7:0] s_mem0 [256];
   logic [7:0] s_mem1 [256];
   logic [7:0] dec_mem0 [32];
   logic [7:0] dec_mem1 [32];
   logic [7:0] enc_rom [32];
   logic [7:0] plain [32];
   logic [7:0] gold_ks [32];
   logic [7:0] gold_s [256];
   logic [7:0] snap [4];

   int checks = 0;
   int errors = 0;

   prga_decrypt_fsm #(.MSG_LEN(32), .MSG_AW(5), .EARLY_ABORT(1'b1)) dut0 (
      .clk(clk), .reset(reset), .start(start0),
      .s_q(s_q0), .s_address(s_address0), .s_data(s_data0), .s_wren(s_wren0),
      .enc_q(enc_q0), .enc_address(enc_address0),
      .dec_address(dec_address0), .dec_data(dec_data0), .dec_wren(dec_wren0),
      .busy(busy0), .done(done0), .msg_valid(msg_valid0)
   );

   prga_decrypt_fsm #(.MSG_LEN(32), .MSG_AW(5), .EARLY_ABORT(1'b0)) dut1 (
      .clk(clk), .reset(reset), .start(start1),
      .s_q(s_q1), .s_address(s_address1), .s_data(s_data1), .s_wren(s_wren1),
      .enc_q(enc_q1), .enc_address(enc_address1),
      .dec_address(dec_address1), .dec_data(dec_data1), .dec_wren(dec_wren1),
      .busy(busy1), .done(done1), .msg_valid(msg_valid1)
   );

   // Synchronous memories: address registered by the DUT, data registered here.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int x = 0; x < 256; x++) begin
            s_mem0[x] <= 8'(x);
            s_mem1[x] <= 8'(x);
         end
         for (int x = 0; x < 32; x++) begin
            dec_mem0[x] <= 8'hee;
            dec_mem1[x] <= 8'hee;
         end
      end else begin
         if (s_wren0)   s_mem0[s_address0]   <= s_data0;
         if (s_wren1)   s_mem1[s_address1]   <= s_data1;
         if (dec_wren0) dec_mem0[dec_address0] <= dec_data0;
         if (dec_wren1) dec_mem1[dec_address1] <= dec_data1;
      end
      s_q0   <= s_mem0[s_address0];
      s_q1   <= s_mem1[s_address1];
      enc_q0 <= enc_rom[enc_address0];
      enc_q1 <= enc_rom[enc_address1];
   end

   logic       done_m, busy_m, s_wren_m, dec_wren_m;
   logic [4:0] dec_address_m;
   assign done_m        = sel ? done1 : done0;
   assign busy_m        = sel ? busy1 : busy0;
   assign s_wren_m      = sel ? s_wren1 : s_wren0;
   assign dec_wren_m    = sel ? dec_wren1 : dec_wren0;
   assign dec_address_m = sel ? dec_address1 : dec_address0;

   // Reference RC4 keystream and final S for an identity-initialised S.
   task automatic gold_model();
      logic [7:0] s [256];
      logic [7:0] i, j, si, sj;
      for (int x = 0; x < 256; x++) s[x] = 8'(x);
      i = 8'd0;
      j = 8'd0;
      for (int kk = 0; kk < 32; kk++) begin
         i = i + 8'd1;
         si = s[i];
         j = j + si;
         sj = s[j];
         s[i] = sj;
         s[j] = si;
         gold_ks[kk] = s[8'(si + sj)];
      end
      for (int x = 0; x < 256; x++) gold_s[x] = s[x];
   endtask

   task automatic set_enc(input bit bad1);
      for (int kk = 0; kk < 32; kk++) begin
         plain[kk] = (kk == 0) ? 8'h61 : (kk == 1) ? 8'h62 : (kk == 2) ? 8'h63 : 8'h20;
         enc_rom[kk] = plain[kk] ^ gold_ks[kk];
      end
      if (bad1) enc_rom[1] = 8'h00;
   endtask

   task automatic init_mem();
      @(negedge clk) mem_init = 1'b1;
      @(negedge clk) mem_init = 1'b0;
   endtask

   // Launch one run on the selected instance; cycles counted from the first busy cycle.
   task automatic run(input bit hold, output int cyc, output int nd, output int stray);
      @(negedge clk);
      if (sel) start1 = 1'b1; else start0 = 1'b1;
      @(negedge clk);
      if (!hold) begin
         start0 = 1'b0;
         start1 = 1'b0;
      end
      cyc = 0;
      nd = 0;
      stray = 0;
      while (!done_m && cyc < 2000) begin
         if (dec_wren_m) begin
            nd++;
            if (!sel && dec_address_m == 5'd2) begin
               snap[0] = s_mem0[1];
               snap[1] = s_mem0[2];
               snap[2] = s_mem0[3];
               snap[3] = s_mem0[5];
            end
         end
         if ((s_wren_m || dec_wren_m) && !busy_m) stray++;
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (busy0 !== 1'b0 || done0 !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy_done got busy=%b done=%b want 0 0", busy0, done0);
      end
      checks++;
      if (msg_valid0 !== 1'b1 || msg_valid1 !== 1'b1) begin
         errors++;
         $display("FAIL reset_msg_valid got %b %b want 1 1", msg_valid0, msg_valid1);
      end
      checks++;
      if (s_wren0 !== 1'b0 || dec_wren0 !== 1'b0 || s_wren1 !== 1'b0 || dec_wren1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_wren got %b%b%b%b want 0000", s_wren0, dec_wren0, s_wren1, dec_wren1);
      end
      checks++;
      if (s_address0 !== 8'h00 || s_data0 !== 8'h00 || dec_data0 !== 8'h00 ||
          enc_address0 !== 5'd0 || dec_address0 !== 5'd0) begin
         errors++;
         $display("FAIL reset_buses got sa=%h sd=%h dd=%h ea=%h da=%h want all 0",
                  s_address0, s_data0, dec_data0, enc_address0, dec_address0);
      end
      @(negedge clk) reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (busy0 !== 1'b0 || busy1 !== 1'b0 || done0 !== 1'b0) begin
         errors++;
         $display("FAIL idle_no_start got busy=%b%b done=%b want 00 0", busy0, busy1, done0);
      end
   endtask

   task automatic test_identity();
      int cyc, nd, stray, bad;
      set_enc(1'b0);
      init_mem();
      sel = 1'b0;
      run(1'b0, cyc, nd, stray);
      checks++;
      if (cyc != 480) begin
         errors++;
         $display("FAIL identity_cycles got %0d want 480", cyc);
      end
      checks++;
      if (nd != 32 || stray != 0) begin
         errors++;
         $display("FAIL identity_writes got dec_writes=%0d stray=%0d want 32 0", nd, stray);
      end
      checks++;
      if (msg_valid0 !== 1'b1 || busy0 !== 1'b0) begin
         errors++;
         $display("FAIL identity_status got valid=%b busy=%b want 1 0", msg_valid0, busy0);
      end
      checks++;
      if (dec_mem0[0] !== 8'h61 || dec_mem0[1] !== 8'h62 || dec_mem0[2] !== 8'h63) begin
         errors++;
         $display("FAIL identity_abc got %h %h %h want 61 62 63", dec_mem0[0], dec_mem0[1], dec_mem0[2]);
      end
      bad = 0;
      for (int x = 3; x < 32; x++) if (dec_mem0[x] !== 8'h20) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL identity_spaces got %0d wrong bytes want 0", bad);
      end
      checks++;
      if (snap[0] !== 8'd1 || snap[1] !== 8'd3 || snap[2] !== 8'd5 || snap[3] !== 8'd2) begin
         errors++;
         $display("FAIL s_after_3 got S1=%0d S2=%0d S3=%0d S5=%0d want 1 3 5 2",
                  snap[0], snap[1], snap[2], snap[3]);
      end
      bad = 0;
      for (int x = 0; x < 256; x++) if (s_mem0[x] !== gold_s[x]) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL identity_s_final got %0d wrong entries want 0", bad);
      end
      @(negedge clk);
      checks++;
      if (done0 !== 1'b0 || msg_valid0 !== 1'b1) begin
         errors++;
         $display("FAIL identity_done_drop got done=%b valid=%b want 0 1", done0, msg_valid0);
      end
   endtask

   task automatic test_early_abort();
      int cyc, nd, stray;
      set_enc(1'b1);
      init_mem();
      sel = 1'b0;
      run(1'b0, cyc, nd, stray);
      checks++;
      if (cyc != 30 || nd != 2) begin
         errors++;
         $display("FAIL abort_timing got cycles=%0d dec_writes=%0d want 30 2", cyc, nd);
      end
      checks++;
      if (msg_valid0 !== 1'b0) begin
         errors++;
         $display("FAIL abort_valid got %b want 0", msg_valid0);
      end
      checks++;
      if (dec_mem0[0] !== 8'h61 || dec_mem0[1] !== 8'h05) begin
         errors++;
         $display("FAIL abort_bytes got %h %h want 61 05", dec_mem0[0], dec_mem0[1]);
      end
      checks++;
      if (dec_mem0[2] !== 8'hee || dec_mem0[31] !== 8'hee) begin
         errors++;
         $display("FAIL abort_untouched got %h %h want ee ee", dec_mem0[2], dec_mem0[31]);
      end
      @(negedge clk);
      checks++;
      if (done0 !== 1'b0 || msg_valid0 !== 1'b0 || stray != 0) begin
         errors++;
         $display("FAIL abort_hold_valid got done=%b valid=%b stray=%0d want 0 0 0", done0, msg_valid0, stray);
      end
   endtask

   task automatic test_no_abort();
      int cyc, nd, stray, bad;
      set_enc(1'b1);
      init_mem();
      sel = 1'b1;
      run(1'b0, cyc, nd, stray);
      checks++;
      if (cyc != 480 || nd != 32 || stray != 0) begin
         errors++;
         $display("FAIL noabort_run got cycles=%0d dec_writes=%0d stray=%0d want 480 32 0", cyc, nd, stray);
      end
      checks++;
      if (msg_valid1 !== 1'b0) begin
         errors++;
         $display("FAIL noabort_valid got %b want 0", msg_valid1);
      end
      checks++;
      if (dec_mem1[0] !== 8'h61 || dec_mem1[1] !== 8'h05 || dec_mem1[2] !== 8'h63 || dec_mem1[31] !== 8'h20) begin
         errors++;
         $display("FAIL noabort_bytes got %h %h %h %h want 61 05 63 20",
                  dec_mem1[0], dec_mem1[1], dec_mem1[2], dec_mem1[31]);
      end
      bad = 0;
      for (int x = 0; x < 256; x++) if (s_mem1[x] !== gold_s[x]) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL noabort_s_final got %0d wrong entries want 0", bad);
      end
      sel = 1'b0;
   endtask

   task automatic test_reset_mid();
      int cyc, nd, stray, bad;
      set_enc(1'b0);
      init_mem();
      sel = 1'b0;
      @(negedge clk) start0 = 1'b1;
      @(negedge clk) start0 = 1'b0;
      repeat (69) @(negedge clk);
      checks++;
      if (s_wren0 !== 1'b1 || busy0 !== 1'b1) begin
         errors++;
         $display("FAIL midrun_swap got s_wren=%b busy=%b want 1 1", s_wren0, busy0);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (s_wren0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 || dec_wren0 !== 1'b0) begin
         errors++;
         $display("FAIL async_reset got s_wren=%b busy=%b done=%b dec_wren=%b want 0 0 0 0",
                  s_wren0, busy0, done0, dec_wren0);
      end
      @(negedge clk) reset = 1'b1;
      init_mem();
      run(1'b0, cyc, nd, stray);
      bad = 0;
      for (int x = 0; x < 32; x++) if (dec_mem0[x] !== plain[x]) bad++;
      checks++;
      if (cyc != 480 || nd != 32 || bad != 0 || msg_valid0 !== 1'b1) begin
         errors++;
         $display("FAIL rerun_after_reset got cycles=%0d writes=%0d bad=%0d valid=%b want 480 32 0 1",
                  cyc, nd, bad, msg_valid0);
      end
      bad = 0;
      for (int x = 0; x < 256; x++) if (s_mem0[x] !== gold_s[x]) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL rerun_s_final got %0d wrong entries want 0", bad);
      end
   endtask

   task automatic test_back_to_back();
      int cyc, nd, stray, bad;
      set_enc(1'b0);
      init_mem();
      sel = 1'b0;
      run(1'b1, cyc, nd, stray);
      checks++;
      if (cyc != 480 || nd != 32 || stray != 0) begin
         errors++;
         $display("FAIL hold_run got cycles=%0d writes=%0d stray=%0d want 480 32 0", cyc, nd, stray);
      end
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (done0 !== 1'b1 || busy0 !== 1'b0 || s_wren0 !== 1'b0 || dec_wren0 !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL hold_in_done got %0d bad cycles want 0", bad);
      end
      start0 = 1'b0;
      @(negedge clk);
      checks++;
      if (done0 !== 1'b0 || msg_valid0 !== 1'b1) begin
         errors++;
         $display("FAIL release_done got done=%b valid=%b want 0 1", done0, msg_valid0);
      end
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (busy0 !== 1'b0 || s_wren0 !== 1'b0 || dec_wren0 !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL idle_quiet got %0d bad cycles want 0", bad);
      end
      init_mem();
      run(1'b0, cyc, nd, stray);
      bad = 0;
      for (int x = 0; x < 32; x++) if (dec_mem0[x] !== plain[x]) bad++;
      checks++;
      if (cyc != 480 || nd != 32 || bad != 0 || stray != 0) begin
         errors++;
         $display("FAIL second_run got cycles=%0d writes=%0d bad=%0d stray=%0d want 480 32 0 0",
                  cyc, nd, bad, stray);
      end
   endtask

   initial begin
      reset    = 1'b0;
      start0   = 1'b0;
      start1   = 1'b0;
      mem_init = 1'b0;
      sel      = 1'b0;
      gold_model();
      test_reset();
      test_identity();
      test_early_abort();
      test_no_abort();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
